// File: rtl/count_seq_checker.sv
// Sequence checker for the 3-bit count stream of the Moore ROM counter.
// It predicts each successor, locks after a run of correct transitions, then flags and tallies deviations.
module count_seq_checker #(
    parameter bit GRAY     = 1'b0,
    parameter int LOCK_LEN = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       count,
    input  logic             err_clr,
    output logic             locked,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       expected
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [4:0]       LOCK_TGT = 5'(LOCK_LEN);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

    state_t           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [2:0]       exp_q, exp_d;
    logic [3:0]       run_q, run_d;
    logic             mism_q, mism_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [ERR_W-1:0] err_base;
    logic             match;
    logic [4:0]       run_inc;

    // Successor ROM for the selected counting sequence.
    function automatic logic [2:0] next_val(input logic [2:0] v);
        logic [2:0] n;
        n = v + 3'd1;
        if (GRAY) begin
            case (v)
                3'd0:    n = 3'd1;
                3'd1:    n = 3'd3;
                3'd3:    n = 3'd2;
                3'd2:    n = 3'd6;
                3'd6:    n = 3'd7;
                3'd7:    n = 3'd5;
                3'd5:    n = 3'd4;
                default: n = 3'd0;
            endcase
        end
        return n;
    endfunction

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        exp_d    = exp_q;
        run_d    = run_q;
        mism_d   = 1'b0;
        match    = (count == next_val(prev_q));
        run_inc  = {1'b0, run_q} + 5'd1;

        if (en) begin
            prev_d = count;
            exp_d  = next_val(count);
            case (state_q)
                IDLE: begin
                    run_d   = 4'd0;
                    state_d = SEARCH;
                end
                SEARCH: begin
                    if (match) begin
                        if (run_inc == LOCK_TGT) begin
                            state_d = LOCKED;
                            run_d   = 4'd0;
                        end else begin
                            run_d = run_inc[3:0];
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        mism_d  = 1'b1;
                        state_d = SEARCH;
                        run_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = 4'd0;
                end
            endcase
        end

        // Clear first, so a simultaneous mismatch still lands as a count of one.
        err_base = err_clr ? '0 : err_q;
        err_d    = (mism_d && (err_base != ERR_MAX)) ? err_base + ERR_ONE : err_base;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            prev_q  <= 3'd0;
            exp_q   <= 3'd0;
            run_q   <= 4'd0;
            mism_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            exp_q   <= exp_d;
            run_q   <= run_d;
            mism_q  <= mism_d;
            err_q   <= err_d;
        end
    end

    assign locked   = (state_q == LOCKED);
    assign mismatch = mism_q;
    assign err_cnt  = err_q;
    assign expected = exp_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: three parameterisations share one stimulus stream,
// each compared against a streak-based reference model after every edge.
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       err_clr;
    logic [2:0] count;

    logic       lk_a, mm_a, lk_b, mm_b, lk_c, mm_c;
    logic [7:0] ec_a, ec_b;
    logic [1:0] ec_c;
    logic [2:0] ex_a, ex_b, ex_c;

    always #5 clk = ~clk;

    count_seq_checker #(.GRAY(1'b0), .LOCK_LEN(4), .ERR_W(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .count(count), .err_clr(err_clr),
        .locked(lk_a), .mismatch(mm_a), .err_cnt(ec_a), .expected(ex_a));

    count_seq_checker #(.GRAY(1'b1), .LOCK_LEN(4), .ERR_W(8)) dut_b (
        .clk(clk), .reset(reset), .en(en), .count(count), .err_clr(err_clr),
        .locked(lk_b), .mismatch(mm_b), .err_cnt(ec_b), .expected(ex_b));

    count_seq_checker #(.GRAY(1'b0), .LOCK_LEN(2), .ERR_W(2)) dut_c (
        .clk(clk), .reset(reset), .en(en), .count(count), .err_clr(err_clr),
        .locked(lk_c), .mismatch(mm_c), .err_cnt(ec_c), .expected(ex_c));

    int total = 0;
    int bad   = 0;

    localparam int NI = 3;
    int m_gray [NI] = '{0, 1, 0};
    int m_len  [NI] = '{4, 4, 2};
    int m_max  [NI] = '{255, 255, 3};
    int m_has  [NI];
    int m_streak [NI];
    int m_last [NI];
    int m_mm   [NI];
    int m_err  [NI];
    int m_exp  [NI];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int genc(input int i);
        return (i ^ (i >> 1)) & 7;
    endfunction

    // Successor: binary increments mod 8; Gray advances the index of the reflected code.
    function automatic int succ(input int g, input int v);
        if (g == 0) return (v + 1) % 8;
        for (int i = 0; i < 8; i++)
            if (genc(i) == v) return genc((i + 1) % 8);
        return 0;
    endfunction

    function automatic int m_locked(input int i);
        return (m_has[i] != 0 && m_streak[i] >= m_len[i]) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_has[i] = 0; m_streak[i] = 0; m_last[i] = 0;
            m_mm[i] = 0; m_err[i] = 0; m_exp[i] = 0;
        end
    endtask

    task automatic model_edge(input int e, input int c, input int clr);
        for (int i = 0; i < NI; i++) begin
            int base;
            base = (clr != 0) ? 0 : m_err[i];
            m_mm[i] = 0;
            if (e != 0) begin
                if (m_has[i] == 0) begin
                    m_has[i] = 1;
                    m_streak[i] = 0;
                end else if (c == succ(m_gray[i], m_last[i])) begin
                    m_streak[i]++;
                end else begin
                    if (m_streak[i] >= m_len[i]) m_mm[i] = 1;
                    m_streak[i] = 0;
                end
                m_last[i] = c;
                m_exp[i] = succ(m_gray[i], c);
            end
            m_err[i] = (m_mm[i] != 0 && base < m_max[i]) ? base + 1 : base;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/a.locked"},   int'(lk_a), m_locked(0));
        chk({tag, "/a.mismatch"}, int'(mm_a), m_mm[0]);
        chk({tag, "/a.err_cnt"},  int'(ec_a), m_err[0]);
        chk({tag, "/a.expected"}, int'(ex_a), m_exp[0]);
        chk({tag, "/b.locked"},   int'(lk_b), m_locked(1));
        chk({tag, "/b.mismatch"}, int'(mm_b), m_mm[1]);
        chk({tag, "/b.err_cnt"},  int'(ec_b), m_err[1]);
        chk({tag, "/b.expected"}, int'(ex_b), m_exp[1]);
        chk({tag, "/c.locked"},   int'(lk_c), m_locked(2));
        chk({tag, "/c.mismatch"}, int'(mm_c), m_mm[2]);
        chk({tag, "/c.err_cnt"},  int'(ec_c), m_err[2]);
        chk({tag, "/c.expected"}, int'(ex_c), m_exp[2]);
    endtask

    // Called at a falling edge: drive, take one rising edge, compare at the next falling edge.
    task automatic step(input int e, input int c, input int clr, input string tag);
        en      = (e != 0);
        count   = 3'(c);
        err_clr = (clr != 0);
        @(posedge clk);
        model_edge(e, c & 7, clr);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic quick_reset();
        en = 1'b0; err_clr = 1'b0;
        reset = 1'b1;
        #1 model_reset();
        #1 reset = 1'b0;
    endtask

    // Reset raised and released between edges; outputs must clear with no clock.
    task automatic async_reset(input string tag);
        en = 1'b0; err_clr = 1'b0;
        #2 reset = 1'b1;
        #1 model_reset();
        check_all(tag);
        chk({tag, "/a.locked0"},   int'(lk_a), 0);
        chk({tag, "/a.err0"},      int'(ec_a), 0);
        chk({tag, "/a.expected0"}, int'(ex_a), 0);
        #1 reset = 1'b0;
        step(0, 0, 0, {tag, "_gap"});
    endtask

    initial begin
        int p, cur, mode, r, e, c, clr;
        reset = 1'b1; en = 1'b0; err_clr = 1'b0; count = 3'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("rst");
        chk("rst/a.locked", int'(lk_a), 0);
        reset = 1'b0;

        // Basic lock then a deviation and relock.
        for (int v = 0; v <= 4; v++) step(1, v, 0, "t1");
        chk("t1/lock",     int'(lk_a), 1);
        chk("t1/expected", int'(ex_a), 5);
        step(1, 5, 0, "t2");
        step(1, 7, 0, "t2");
        chk("t2/mismatch", int'(mm_a), 1);
        chk("t2/err",      int'(ec_a), 1);
        chk("t2/unlock",   int'(lk_a), 0);
        step(1, 0, 0, "t2");
        chk("t2/pulse_end", int'(mm_a), 0);
        step(1, 1, 0, "t2");
        step(1, 2, 0, "t2");
        chk("t2/not_yet", int'(lk_a), 0);
        step(1, 3, 0, "t2");
        chk("t2/relock", int'(lk_a), 1);

        // Wrap-around with en gaps.
        quick_reset();
        step(1, 6, 0, "t3");
        step(1, 7, 0, "t3");
        step(0, 3, 0, "t3_gap");
        step(0, 5, 0, "t3_gap");
        step(1, 0, 0, "t3");
        step(1, 1, 0, "t3");
        chk("t3/not_yet", int'(lk_a), 0);
        step(1, 2, 0, "t3");
        chk("t3/lock", int'(lk_a), 1);

        // Gray sequence, then a binary stream that must not lock the Gray checker.
        quick_reset();
        step(1, 0, 0, "t4"); step(1, 1, 0, "t4"); step(1, 3, 0, "t4");
        step(1, 2, 0, "t4"); step(1, 6, 0, "t4");
        chk("t4/gray_lock", int'(lk_b), 1);
        for (int v = 0; v <= 5; v++) begin
            step(1, v, 0, "t4b");
            chk("t4b/no_lock", int'(lk_b), 0);
        end

        // Saturation on the 2-bit counter, then clear with a simultaneous mismatch.
        quick_reset();
        step(1, 0, 0, "t5"); step(1, 1, 0, "t5"); step(1, 2, 0, "t5");
        chk("t5/lock", int'(lk_c), 1);
        p = 2;
        for (int k = 0; k < 5; k++) begin
            p = (p + 3) % 8;
            step(1, p, 0, "t5_bad");
            chk("t5/mismatch", int'(mm_c), 1);
            chk("t5/err_sat", int'(ec_c), (k + 1 < 3) ? k + 1 : 3);
            step(1, (p + 1) % 8, 0, "t5_re");
            step(1, (p + 2) % 8, 0, "t5_re");
            p = (p + 2) % 8;
            chk("t5/relock", int'(lk_c), 1);
        end
        step(1, (p + 3) % 8, 1, "t5_clr");
        chk("t5/clr_mismatch", int'(ec_c), 1);

        // Asynchronous reset while locked with two errors logged.
        quick_reset();
        for (int v = 0; v <= 4; v++) step(1, v, 0, "t6");
        step(1, 7, 0, "t6");
        for (int v = 0; v <= 3; v++) step(1, v, 0, "t6");
        step(1, 6, 0, "t6");
        step(1, 7, 0, "t6"); step(1, 0, 0, "t6"); step(1, 1, 0, "t6"); step(1, 2, 0, "t6");
        chk("t6/locked", int'(lk_a), 1);
        chk("t6/err2",   int'(ec_a), 2);
        async_reset("t6_arst");
        step(1, 5, 0, "t6_after");
        chk("t6/search",   int'(lk_a), 0);
        chk("t6/expected", int'(ex_a), 6);
        step(1, 6, 0, "t6_after"); step(1, 7, 0, "t6_after"); step(1, 0, 0, "t6_after");
        chk("t6/not_yet", int'(lk_a), 0);
        step(1, 1, 0, "t6_after");
        chk("t6/relock", int'(lk_a), 1);

        // Randomized streams: mostly-correct sequences in either mode, with faults, holds and gaps.
        quick_reset();
        cur = 0; mode = 0;
        for (int n = 0; n < 1500; n++) begin
            if (n % 60 == 0) mode = int'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 99));
            e   = (r < 85) ? 1 : 0;
            clr = ($urandom_range(0, 49) == 0) ? 1 : 0;
            if (e == 0 || r < 5) c = int'($urandom_range(0, 7));
            else if (r < 9)      c = cur;
            else                 c = succ(mode, cur);
            if (e != 0) cur = c;
            step(e, c, clr, "rnd");
            if ($urandom_range(0, 399) == 0) async_reset("rnd_arst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
